sistema_ram_dp: RTL and testbench

- Parametrised on-chip memory with two independent Avalon-MM slave ports (s1, s2) sharing one array.
- Supports byte-enabled writes, a configurable fixed read latency with readdatavalid, and clock-enable/reset_req stalling.
- Deterministic cross-port collision resolution.
- Next-generation replacement for the single-port, unregistered-output system RAMs in the SISTEMA Qsys fabric.

---
 rtl/sistema_ram_dp.sv | 125 ++++++++++++
 tb/tb_sistema_ram_dp.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sistema_ram_dp.sv
// Shared-array dual-port Avalon-MM RAM: byte-enabled writes, 1- or 2-cycle registered
// reads with readdatavalid, clken/reset_req stalling and s1-priority write collisions.
module sistema_ram_dp #(
    parameter int    DATA_WIDTH   = 32,
    parameter int    ADDR_WIDTH   = 14,
    parameter int    DEPTH        = 16384,
    parameter int    READ_LATENCY = 1,
    parameter int    DUAL_PORT    = 1,
    parameter string INIT_FILE    = "SISTEMA_RAM2.hex"
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clken,
    input  logic                      reset_req,
    input  logic [ADDR_WIDTH-1:0]     s1_address,
    input  logic                      s1_chipselect,
    input  logic                      s1_read,
    input  logic                      s1_write,
    input  logic [DATA_WIDTH/8-1:0]   s1_byteenable,
    input  logic [DATA_WIDTH-1:0]     s1_writedata,
    output logic [DATA_WIDTH-1:0]     s1_readdata,
    output logic                      s1_readdatavalid,
    input  logic [ADDR_WIDTH-1:0]     s2_address,
    input  logic                      s2_chipselect,
    input  logic                      s2_read,
    input  logic                      s2_write,
    input  logic [DATA_WIDTH/8-1:0]   s2_byteenable,
    input  logic [DATA_WIDTH-1:0]     s2_writedata,
    output logic [DATA_WIDTH-1:0]     s2_readdata,
    output logic                      s2_readdatavalid
);

    localparam int                  BYTES   = DATA_WIDTH / 8;
    localparam int                  MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic                S2_ON   = (DUAL_PORT != 0);

    logic                       w_en;
    logic [1:0]                 w_cs;
    logic [1:0]                 w_rd;
    logic [1:0]                 w_wr;
    logic [1:0]                 w_rd_acc;
    logic [1:0]                 w_wr_acc;
    logic [1:0]                 w_in_range;
    logic [1:0][ADDR_WIDTH-1:0] w_addr;
    logic [1:0][BYTES-1:0]      w_be;
    logic [1:0][DATA_WIDTH-1:0] w_wdata;
    logic [1:0][DATA_WIDTH-1:0] w_rdata;
    logic [1:0]                 w_rdv;

    // Port 1 (index 1) is forced idle when s2 is disabled so its logic prunes away.
    assign w_en       = clken & ~reset_req;
    assign w_cs       = {s2_chipselect & S2_ON, s1_chipselect};
    assign w_rd       = {s2_read, s1_read};
    assign w_wr       = {s2_write, s1_write};
    assign w_addr     = {s2_address, s1_address};
    assign w_be       = {s2_byteenable, s1_byteenable};
    assign w_wdata    = {s2_writedata, s1_writedata};
    assign w_rd_acc   = w_cs & w_rd & ~w_wr & {2{w_en}};
    assign w_wr_acc   = w_cs & w_wr & {2{w_en}};
    assign w_in_range = {({1'b0, s2_address} < DEPTH_L), ({1'b0, s1_address} < DEPTH_L)};

    (* ram_init_file = INIT_FILE *)
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // NOTE: the array has no reset; s2 lanes are written before s1 so s1's later NBA wins shared lanes.
    always_ff @(posedge clk) begin
        for (int p = 1; p >= 0; p--) begin
            if (w_wr_acc[p] && w_in_range[p]) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (w_be[p][b]) begin
                        r_mem[w_addr[p][MEM_AW-1:0]][8*b +: 8] <= w_wdata[p][8*b +: 8];
                    end
                end
            end
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [DATA_WIDTH-1:0] r_data1;
        logic                  r_valid1;

        // NOTE: the array read sits beside the writes' NBAs, so a same-cycle cross-port read sees old data.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_data1  <= '0;
                r_valid1 <= 1'b0;
            end else if (w_en) begin
                r_valid1 <= w_rd_acc[p];
                if (w_rd_acc[p]) begin
                    r_data1 <= w_in_range[p] ? r_mem[w_addr[p][MEM_AW-1:0]] : '0;
                end
            end
        end

        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] r_data2;
            logic                  r_valid2;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_data2  <= '0;
                    r_valid2 <= 1'b0;
                end else if (w_en) begin
                    r_valid2 <= r_valid1;
                    if (r_valid1) begin
                        r_data2 <= r_data1;
                    end
                end
            end

            assign w_rdata[p] = r_data2;
            assign w_rdv[p]   = r_valid2;
        end else begin : g_lat1
            assign w_rdata[p] = r_data1;
            assign w_rdv[p]   = r_valid1;
        end
    end

    assign s1_readdata      = w_rdata[0];
    assign s1_readdatavalid = w_rdv[0];
    assign s2_readdata      = S2_ON ? w_rdata[1] : '0;
    assign s2_readdatavalid = S2_ON & w_rdv[1];

endmodule

// File: tb/tb_sistema_ram_dp.sv
// Bench for sistema_ram_dp: dut 0 = 8K words, latency 1, dual port; dut 1 = 16K words,
// latency 2, single port. Both see the same stimulus and are checked against a queue model.
module tb_sistema_ram_dp;

    typedef struct {
        int          due;
        logic [31:0] data;
    } pend_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        clken;
    logic        reset_req;
    logic [13:0] addr [2];
    logic        cs   [2];
    logic        rd   [2];
    logic        wr   [2];
    logic [3:0]  be   [2];
    logic [31:0] wd   [2];
    logic [31:0] rdata [2][2];
    logic        rdv   [2][2];

    int          depth_m [2] = '{8192, 16384};
    int          lat_m   [2] = '{1, 2};
    bit          dual_m  [2] = '{1'b1, 1'b0};
    logic [31:0] mem_m   [2][16384];
    pend_t       pend_q  [2][2][$];
    logic [31:0] exp_rd  [2][2];
    logic        exp_v   [2][2];
    int          ecnt    [2];
    bit          last_en;
    bit          counting;
    int          pulses  [2];
    logic [31:0] seen_q  [2][$];
    logic [31:0] pre     [64];
    int          n_tests;
    int          n_fail;

    always #5 clk = ~clk;

    sistema_ram_dp #(
        .DATA_WIDTH(32), .ADDR_WIDTH(14), .DEPTH(8192), .READ_LATENCY(1),
        .DUAL_PORT(1), .INIT_FILE("")
    ) u_dut_a (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
        .s1_address(addr[0]), .s1_chipselect(cs[0]), .s1_read(rd[0]), .s1_write(wr[0]),
        .s1_byteenable(be[0]), .s1_writedata(wd[0]),
        .s1_readdata(rdata[0][0]), .s1_readdatavalid(rdv[0][0]),
        .s2_address(addr[1]), .s2_chipselect(cs[1]), .s2_read(rd[1]), .s2_write(wr[1]),
        .s2_byteenable(be[1]), .s2_writedata(wd[1]),
        .s2_readdata(rdata[0][1]), .s2_readdatavalid(rdv[0][1])
    );

    sistema_ram_dp #(
        .DATA_WIDTH(32), .ADDR_WIDTH(14), .DEPTH(16384), .READ_LATENCY(2),
        .DUAL_PORT(0), .INIT_FILE("")
    ) u_dut_b (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
        .s1_address(addr[0]), .s1_chipselect(cs[0]), .s1_read(rd[0]), .s1_write(wr[0]),
        .s1_byteenable(be[0]), .s1_writedata(wd[0]),
        .s1_readdata(rdata[1][0]), .s1_readdatavalid(rdv[1][0]),
        .s2_address(addr[1]), .s2_chipselect(cs[1]), .s2_read(rd[1]), .s2_write(wr[1]),
        .s2_byteenable(be[1]), .s2_writedata(wd[1]),
        .s2_readdata(rdata[1][1]), .s2_readdatavalid(rdv[1][1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: reads capture data at acceptance and surface lat-1 enabled edges later.
    task automatic model_edge();
        bit en;
        en      = clken && !reset_req;
        last_en = en && !reset;
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                for (int p = 0; p < 2; p++) begin
                    pend_q[d][p].delete();
                    exp_rd[d][p] = '0;
                    exp_v[d][p]  = 1'b0;
                end
            end else if (en) begin
                ecnt[d]++;
                for (int p = 0; p < 2; p++) begin
                    if ((p == 0 || dual_m[d]) && cs[p] && rd[p] && !wr[p]) begin
                        pend_t e;
                        e.due  = ecnt[d] + lat_m[d] - 1;
                        e.data = (int'(addr[p]) < depth_m[d]) ? mem_m[d][addr[p]] : 32'h0;
                        pend_q[d][p].push_back(e);
                    end
                    if (pend_q[d][p].size() > 0 && pend_q[d][p][0].due == ecnt[d]) begin
                        exp_v[d][p]  = 1'b1;
                        exp_rd[d][p] = pend_q[d][p][0].data;
                        void'(pend_q[d][p].pop_front());
                    end else begin
                        exp_v[d][p] = 1'b0;
                    end
                end
            end
            if (en) begin
                for (int p = 1; p >= 0; p--) begin
                    if ((p == 0 || dual_m[d]) && cs[p] && wr[p] && int'(addr[p]) < depth_m[d]) begin
                        for (int b = 0; b < 4; b++) begin
                            if (be[p][b]) mem_m[d][addr[p]][8*b +: 8] = wd[p][8*b +: 8];
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("dut%0d_s%0d_readdata", d, p + 1), rdata[d][p], exp_rd[d][p]);
                chk($sformatf("dut%0d_s%0d_valid", d, p + 1), {31'b0, rdv[d][p]}, {31'b0, exp_v[d][p]});
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
        if (counting && last_en) begin
            for (int d = 0; d < 2; d++) begin
                if (rdv[d][0]) begin
                    pulses[d]++;
                    seen_q[d].push_back(rdata[d][0]);
                end
            end
        end
    endtask

    task automatic idle();
        for (int p = 0; p < 2; p++) begin
            cs[p] = 1'b0; rd[p] = 1'b0; wr[p] = 1'b0; be[p] = 4'h0; wd[p] = 32'h0; addr[p] = 14'h0;
        end
    endtask

    task automatic do_wr(input int p, input logic [13:0] a, input logic [3:0] b, input logic [31:0] d);
        cs[p] = 1'b1; rd[p] = 1'b0; wr[p] = 1'b1; addr[p] = a; be[p] = b; wd[p] = d;
    endtask

    task automatic do_rd(input int p, input logic [13:0] a);
        cs[p] = 1'b1; rd[p] = 1'b1; wr[p] = 1'b0; addr[p] = a;
    endtask

    initial begin
        logic [31:0] top_val;
        n_tests = 0; n_fail = 0; counting = 1'b0;
        reset = 1'b1; clken = 1'b1; reset_req = 1'b0;
        idle();
        tick(); tick();
        chk("reset_s1_valid", {31'b0, rdv[0][0]}, 32'h0);
        chk("reset_s1_data", rdata[0][0], 32'h0);
        reset = 1'b0;

        // Preload words 0..63 and the top word (out of range for the 8K dut).
        for (int a = 0; a < 64; a++) begin
            pre[a] = $urandom;
            do_wr(0, 14'(a), 4'hF, pre[a]);
            tick();
        end
        top_val = $urandom;
        do_wr(0, 14'h3FFF, 4'hF, top_val);
        tick();

        do_wr(0, 14'h0, 4'hF, 32'hDEADBEEF); tick();
        do_rd(0, 14'h0); tick();
        chk("lat1_data", rdata[0][0], 32'hDEADBEEF);
        chk("lat1_valid", {31'b0, rdv[0][0]}, 32'h1);
        chk("lat2_not_yet", {31'b0, rdv[1][0]}, 32'h0);
        idle(); tick();
        chk("lat2_data", rdata[1][0], 32'hDEADBEEF);
        chk("lat2_valid", {31'b0, rdv[1][0]}, 32'h1);

        do_wr(0, 14'h10, 4'hF, 32'h11223344); tick();
        do_wr(0, 14'h10, 4'b0101, 32'hAABBCCDD); tick();
        idle(); do_rd(1, 14'h10); tick();
        chk("byteenable_merge", rdata[0][1], 32'h11BB33DD);

        idle(); do_wr(0, 14'h20, 4'hF, 32'h0); tick();
        do_wr(0, 14'h20, 4'b0001, 32'h000000AA);
        do_wr(1, 14'h20, 4'b0011, 32'h0000BBCC); tick();
        idle(); do_rd(0, 14'h20); tick();
        chk("ww_collision", rdata[0][0], 32'h0000BBAA);

        idle(); do_wr(0, 14'h30, 4'hF, 32'h5); tick();
        do_wr(0, 14'h30, 4'hF, 32'h9); do_rd(1, 14'h30); tick();
        chk("read_first_old", rdata[0][1], 32'h5);
        idle(); do_rd(1, 14'h30); tick();
        chk("read_after_write", rdata[0][1], 32'h9);

        // Burst with a clken gap and a reset_req cycle.
        idle(); tick(); tick();
        counting = 1'b1; pulses = '{0, 0};
        do_rd(0, 14'h38); tick();
        do_rd(0, 14'h39); tick();
        idle(); clken = 1'b0; tick(); tick(); tick();
        clken = 1'b1; do_rd(0, 14'h3A); tick();
        do_rd(0, 14'h3B); tick();
        idle(); reset_req = 1'b1; tick();
        reset_req = 1'b0; tick(); tick(); tick();
        counting = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("burst_pulses_dut%0d", d), 32'(pulses[d]), 32'd4);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("burst_order_dut%0d_%0d", d, i),
                    (i < seen_q[d].size()) ? seen_q[d][i] : ~pre[56 + i], pre[56 + i]);
            end
        end

        do_rd(0, 14'h5); tick();
        idle(); reset = 1'b1; tick();
        chk("flush_valid", {31'b0, rdv[1][0]}, 32'h0);
        chk("flush_data", rdata[1][0], 32'h0);
        reset = 1'b0; tick(); tick();
        chk("flush_no_late_valid", {31'b0, rdv[1][0]}, 32'h0);

        do_rd(0, 14'h3FFF); tick();
        chk("oor_data", rdata[0][0], 32'h0);
        chk("oor_valid", {31'b0, rdv[0][0]}, 32'h1);
        idle(); tick();
        chk("top_word_in_range", rdata[1][0], top_val);

        do_rd(1, 14'h10); tick(); tick();
        chk("s2_off_valid", {31'b0, rdv[1][1]}, 32'h0);
        chk("s2_off_data", rdata[1][1], 32'h0);

        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(0, 49) == 0);
            clken     = ($urandom_range(0, 9) != 0);
            reset_req = ($urandom_range(0, 19) == 0);
            for (int p = 0; p < 2; p++) begin
                cs[p]   = !reset && ($urandom_range(0, 3) != 0);
                rd[p]   = 1'($urandom_range(0, 1));
                wr[p]   = ($urandom_range(0, 3) == 0);
                addr[p] = ($urandom_range(0, 9) == 0) ? 14'h3FFF : 14'($urandom_range(0, 63));
                be[p]   = 4'($urandom_range(0, 15));
                wd[p]   = $urandom;
            end
            tick();
        end
        reset = 1'b0; clken = 1'b1; reset_req = 1'b0;
        idle(); tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
